// File: rtl/bus_register_core.sv
// bus_register_core: register file, special registers and priority-encoded shared bus for a simple CPU datapath.
module bus_register_core #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [15:0]   Rin,
  input  logic [15:0]   Rout,
  input  logic          PCin,
  input  logic          IRin,
  input  logic          Yin,
  input  logic          Zin,
  input  logic          HIin,
  input  logic          LOin,
  input  logic          MDRin,
  input  logic          PCout,
  input  logic          HIout,
  input  logic          LOout,
  input  logic          Zhighout,
  input  logic          Zlowout,
  input  logic          MDRout,
  input  logic          InPortout,
  input  logic          Cout,
  input  logic          Read,
  input  logic [DW-1:0] MDatain,
  input  logic [DW-1:0] InPort_data,
  input  logic [DW-1:0] C_sign_extended,
  input  logic [DW-1:0] alu_hi,
  input  logic [DW-1:0] alu_lo,
  output logic [DW-1:0] BusMuxOut,
  output logic [DW-1:0] Y_q,
  output logic [DW-1:0] IR_q,
  output logic [4:0]    bus_sel
);
  logic [DW-1:0] gpr_q [16];
  logic [DW-1:0] pc_q, hi_q, lo_q, zhi_q, zlo_q, mdr_q, mdr_d;
  logic [31:0]   enc_in;
  assign enc_in = {8'b0, Cout, InPortout, MDRout, PCout, Zlowout, Zhighout, LOout, HIout, Rout};
  // Ascending scan leaves the highest asserted request; 31 when none.
  always_comb begin
    bus_sel = 5'd31;
    for (int i = 0; i < 32; i++) if (enc_in[i]) bus_sel = 5'(i);
  end
  always_comb begin
    case (bus_sel)
      5'd16:   BusMuxOut = hi_q;
      5'd17:   BusMuxOut = lo_q;
      5'd18:   BusMuxOut = zhi_q;
      5'd19:   BusMuxOut = zlo_q;
      5'd20:   BusMuxOut = pc_q;
      5'd21:   BusMuxOut = mdr_q;
      5'd22:   BusMuxOut = InPort_data;
      5'd23:   BusMuxOut = C_sign_extended;
      default: BusMuxOut = bus_sel[4] ? '0 : gpr_q[bus_sel[3:0]];
    endcase
  end
  assign mdr_d = Read ? MDatain : BusMuxOut;
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < 16; i++) gpr_q[i] <= '0;
      pc_q  <= '0;
      IR_q  <= '0;
      Y_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      zhi_q <= '0;
      zlo_q <= '0;
      mdr_q <= '0;
    end else begin
      for (int i = 0; i < 16; i++) if (Rin[i]) gpr_q[i] <= BusMuxOut;
      if (PCin)  pc_q  <= BusMuxOut;
      if (IRin)  IR_q  <= BusMuxOut;
      if (Yin)   Y_q   <= BusMuxOut;
      if (HIin)  hi_q  <= BusMuxOut;
      if (LOin)  lo_q  <= BusMuxOut;
      if (Zin)   zhi_q <= alu_hi;
      if (Zin)   zlo_q <= alu_lo;
      if (MDRin) mdr_q <= mdr_d;
    end
  end
endmodule

// File: tb/tb_bus_register_core.sv
// tb_bus_register_core: scoreboard bench; expected bus value/select pushed on drive, popped when the bus is sampled.
module tb_bus_register_core;
  logic        clk = 1'b0;
  logic        clr;
  logic [15:0] Rin, Rout;
  logic        PCin, IRin, Yin, Zin, HIin, LOin, MDRin;
  logic        PCout, HIout, LOout, Zhighout, Zlowout, MDRout, InPortout, Cout, Read;
  logic [31:0] MDatain, InPort_data, C_sign_extended, alu_hi, alu_lo;
  logic [31:0] BusMuxOut, Y_q, IR_q;
  logic [4:0]  bus_sel;
  int n_chk = 0;
  int n_bad = 0;
  typedef struct {
    string       tag;
    logic [31:0] bus;
    logic [4:0]  sel;
  } exp_t;
  exp_t sb[$];

  bus_register_core #(.DW(32)) dut (
    .clk(clk), .clr(clr), .Rin(Rin), .Rout(Rout),
    .PCin(PCin), .IRin(IRin), .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin), .MDRin(MDRin),
    .PCout(PCout), .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .MDRout(MDRout), .InPortout(InPortout), .Cout(Cout), .Read(Read),
    .MDatain(MDatain), .InPort_data(InPort_data), .C_sign_extended(C_sign_extended),
    .alu_hi(alu_hi), .alu_lo(alu_lo),
    .BusMuxOut(BusMuxOut), .Y_q(Y_q), .IR_q(IR_q), .bus_sel(bus_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    Rin = '0; Rout = '0;
    {PCin, IRin, Yin, Zin, HIin, LOin, MDRin} = '0;
    {PCout, HIout, LOout, Zhighout, Zlowout, MDRout, InPortout, Cout, Read} = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic expect_bus(input string tag, input logic [31:0] bus, input logic [4:0] sel);
    sb.push_back('{tag, bus, sel});
  endtask

  task automatic observe();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, "_bus"}, BusMuxOut, e.bus);
      chk({e.tag, "_sel"}, {27'd0, bus_sel}, {27'd0, e.sel});
    end
  endtask

  task automatic load_const(input logic [31:0] v, input int r);
    C_sign_extended = v; Cout = 1'b1; Rin[r] = 1'b1;
    tick();
  endtask

  task automatic show_reg(input string tag, input int r, input logic [31:0] v);
    Rout[r] = 1'b1;
    expect_bus(tag, v, 5'(r));
    observe();
    Rout = '0;
  endtask

  initial begin
    idle();
    clr = 1'b0;
    MDatain = '0; InPort_data = '0; C_sign_extended = '0; alu_hi = '0; alu_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    expect_bus("reset_idle", 32'h0, 5'd31);
    observe();
    chk("reset_y", Y_q, 32'h0);
    chk("reset_ir", IR_q, 32'h0);
    #2 clr = 1'b1;
    // MDR from memory, then onto the bus
    MDatain = 32'h12345678; Read = 1'b1; MDRin = 1'b1;
    tick();
    MDRout = 1'b1;
    expect_bus("mdr_mem", 32'h12345678, 5'd21);
    observe();
    // MDR -> R2
    MDatain = 32'h22; Read = 1'b1; MDRin = 1'b1;
    tick();
    MDRout = 1'b1; Rin[2] = 1'b1;
    tick();
    show_reg("r2", 2, 32'h22);
    // priority between two GPRs
    load_const(32'h55, 7);
    Rout[2] = 1'b1; Rout[7] = 1'b1;
    expect_bus("prio_r7", 32'h55, 5'd7);
    observe();
    idle();
    // Z capture
    alu_hi = 32'hAAAA0000; alu_lo = 32'h0000BBBB; Zin = 1'b1;
    tick();
    Zhighout = 1'b1;
    expect_bus("zhi", 32'hAAAA0000, 5'd18);
    observe();
    idle(); Zlowout = 1'b1;
    expect_bus("zlo", 32'h0000BBBB, 5'd19);
    observe();
    idle();
    // constant into MDR through the bus
    C_sign_extended = 32'hFFFFFFF0; Cout = 1'b1; MDRin = 1'b1;
    expect_bus("cout", 32'hFFFFFFF0, 5'd23);
    observe();
    tick();
    MDRout = 1'b1;
    expect_bus("mdr_c", 32'hFFFFFFF0, 5'd21);
    observe();
    idle();
    // Y and IR from input port / constant
    InPort_data = 32'hCAFEF00D; InPortout = 1'b1; Yin = 1'b1;
    expect_bus("inport", 32'hCAFEF00D, 5'd22);
    observe();
    tick();
    chk("y_load", Y_q, 32'hCAFEF00D);
    C_sign_extended = 32'h0BADC0DE; Cout = 1'b1; IRin = 1'b1;
    tick();
    chk("ir_load", IR_q, 32'h0BADC0DE);
    chk("y_hold", Y_q, 32'hCAFEF00D);
    // self drive and load
    load_const(32'h33, 3);
    Rout[3] = 1'b1; Rin[3] = 1'b1;
    tick();
    show_reg("r3_self", 3, 32'h33);
    // multiple loads from one bus value
    C_sign_extended = 32'h77; Cout = 1'b1;
    Rin[4] = 1'b1; Rin[9] = 1'b1; PCin = 1'b1; HIin = 1'b1; LOin = 1'b1;
    tick();
    show_reg("multi_r4", 4, 32'h77);
    show_reg("multi_r9", 9, 32'h77);
    PCout = 1'b1; expect_bus("multi_pc", 32'h77, 5'd20); observe(); idle();
    HIout = 1'b1; expect_bus("multi_hi", 32'h77, 5'd16); observe(); idle();
    LOout = 1'b1; expect_bus("multi_lo", 32'h77, 5'd17); observe(); idle();
    PCout = 1'b1; Cout = 1'b1; C_sign_extended = 32'h1;
    expect_bus("prio_cout", 32'h1, 5'd23);
    observe();
    idle();
    show_reg("r2_hold", 2, 32'h22);
    // asynchronous clear mid-cycle
    load_const(32'hDEADBEEF, 5);
    show_reg("r5", 5, 32'hDEADBEEF);
    Rout[5] = 1'b1;
    #2 clr = 1'b0;
    expect_bus("r5_clr", 32'h0, 5'd5);
    observe();
    Rout = '0;
    expect_bus("clr_idle", 32'h0, 5'd31);
    observe();
    chk("clr_y", Y_q, 32'h0);
    chk("clr_ir", IR_q, 32'h0);
    C_sign_extended = 32'h99; Cout = 1'b1; Rin[5] = 1'b1; Yin = 1'b1;
    tick();
    chk("clr_ignore_y", Y_q, 32'h0);
    show_reg("clr_ignore_r5", 5, 32'h0);
    show_reg("clr_r2", 2, 32'h0);
    #2 clr = 1'b1;
    load_const(32'h5A5A5A5A, 5);
    show_reg("resume_r5", 5, 32'h5A5A5A5A);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
